// File: rtl/gray_rx_decoder.sv
// gray_rx_decoder: Gray-count receiver with binary decode, step/error pulses, lock FSM and saturating error counter.
// Optional input synchronizer enabled by defining GRAY_SYNC_EN.
module gray_rx_decoder #(
  parameter int N = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic [N-1:0]     gray_in,
  input  logic             err_clr,
  output logic [N-1:0]     bin_out,
  output logic             step_up,
  output logic             step_dn,
  output logic             err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);
  typedef enum logic [1:0] {IDLE, LOCK, FAULT} state_t;
  state_t state, state_nx;
  logic [N-1:0] src, gray_q, bin_prev, bin_d, delta;
  logic [ERR_W-1:0] cnt_nx;
  logic vld, dec, up_nx, dn_nx, err_nx, legal;
  function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
`ifdef GRAY_SYNC_EN
  logic [N-1:0] sync1, sync2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gray_in;
      sync2 <= sync1;
    end
  assign src = sync2;
`else
  assign src = gray_in;
`endif
  assign dec = clk_en & vld;
  assign bin_d = gray2bin(gray_q);
  assign delta = bin_d - bin_prev;
  assign legal = (delta == '0) || (delta == N'(1)) || (delta == '1);
  assign locked = state == LOCK;
  always_comb begin
    state_nx = state;
    up_nx = 1'b0;
    dn_nx = 1'b0;
    err_nx = 1'b0;
    cnt_nx = err_count;
    if (err_clr) begin
      state_nx = IDLE;
      cnt_nx = '0;
    end else if (dec) begin
      case (state)
        IDLE: state_nx = LOCK;
        LOCK: begin
          up_nx = delta == N'(1);
          dn_nx = delta == '1;
          state_nx = legal ? LOCK : FAULT;
        end
        default: state_nx = FAULT;
      endcase
      if (state != IDLE && !legal) begin
        err_nx = 1'b1;
        cnt_nx = err_count + ERR_W'(err_count != '1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      gray_q <= '0;
      vld <= 1'b0;
      bin_prev <= '0;
      bin_out <= '0;
      step_up <= 1'b0;
      step_dn <= 1'b0;
      err <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_nx;
      gray_q <= clk_en ? src : gray_q;
      vld <= vld | clk_en;
      bin_prev <= dec ? bin_d : bin_prev;
      bin_out <= dec ? bin_d : bin_out;
      step_up <= up_nx;
      step_dn <= dn_nx;
      err <= err_nx;
      err_count <= cnt_nx;
    end
endmodule

// File: tb/tb_gray_rx_decoder.sv
// tb_gray_rx_decoder: directed scoreboard bench for gray_rx_decoder (N=4, ERR_W=8).
module tb_gray_rx_decoder;
  localparam int N = 4;
  localparam int M = (1 << N) - 1;
  logic clk = 1'b0, rst_n, clk_en, err_clr;
  logic [N-1:0] gray_in, bin_out;
  logic step_up, step_dn, err, locked;
  logic [7:0] err_count;
  typedef struct {int due; int bin; bit up; bit dn; bit er;} exp_t;
  exp_t q[$];
  int errs = 0, checks = 0, cycle = 0;
  int mst = 0, mcnt = 0, mprev = 0, mbin = 0, pb = 0, sb1 = 0, sb2 = 0;
  bit pv = 0;
  gray_rx_decoder #(.N(N), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .gray_in(gray_in), .err_clr(err_clr),
    .bin_out(bin_out), .step_up(step_up), .step_dn(step_dn), .err(err),
    .locked(locked), .err_count(err_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s cycle=%0d got=%0d exp=%0d", tag, cycle, got, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, ".bin"}, 32'(bin_out), 0);
    chk({tag, ".pulses"}, {29'd0, step_up, step_dn, err}, 0);
    chk({tag, ".locked"}, 32'(locked), 0);
    chk({tag, ".cnt"}, 32'(err_count), 0);
  endtask
  task automatic model_reset();
    mst = 0; mcnt = 0; mbin = 0; pv = 0; sb1 = 0; sb2 = 0;
    q.delete();
  endtask
  task automatic cyc(input int b, input bit en = 1'b1, input bit clr = 1'b0);
    int d, src;
    exp_t e;
    gray_in = N'(b ^ (b >> 1));
    clk_en = en;
    err_clr = clr;
`ifdef GRAY_SYNC_EN
    src = sb2;
`else
    src = b;
`endif
    if (en && pv) begin
      d = (pb - mprev) & M;
      e = '{cycle + 1, pb, 1'b0, 1'b0, 1'b0};
      if (!clr) begin
        if (mst == 0) mst = 1;
        else if (d != 0 && d != 1 && d != M) begin
          e.er = 1'b1;
          if (mcnt < 255) mcnt++;
          mst = 2;
        end else if (mst == 1) begin
          e.up = d == 1;
          e.dn = d == M;
        end
      end
      mprev = pb;
      mbin = pb;
      q.push_back(e);
    end
    if (clr) begin mst = 0; mcnt = 0; end
    if (en) begin pb = src; pv = 1'b1; end
    sb2 = sb1;
    sb1 = b;
    @(posedge clk);
    #1;
    cycle++;
    if (q.size() > 0 && q[0].due == cycle) begin
      e = q.pop_front();
      chk("bin_out", 32'(bin_out), 32'(e.bin));
      chk("step_up", 32'(step_up), 32'(e.up));
      chk("step_dn", 32'(step_dn), 32'(e.dn));
      chk("err", 32'(err), 32'(e.er));
    end else begin
      chk("hold.bin", 32'(bin_out), 32'(mbin));
      chk("idle.pulses", {29'd0, step_up, step_dn, err}, 0);
    end
    chk("locked", 32'(locked), 32'(mst == 1));
    chk("err_count", 32'(err_count), 32'(mcnt));
  endtask
  initial begin
    rst_n = 1'b0; clk_en = 1'b0; err_clr = 1'b0; gray_in = '0;
    #12;
    chk_zero("reset");
    rst_n = 1'b1;
    cyc(0); cyc(1); cyc(2); cyc(2);
    cyc(15); cyc(0); cyc(0); cyc(15);
    cyc(1); cyc(4); cyc(5); cyc(6);
    cyc(9); cyc(10, 1'b1, 1'b1); cyc(11); cyc(12); cyc(12);
    cyc(13); cyc(13, 1'b0); cyc(13, 1'b0); cyc(14); cyc(14, 1'b0); cyc(14); cyc(15);
    for (int i = 0; i < 300; i++) cyc((i % 2) ? 8 : 0);
    cyc(0); cyc(0);
    chk("saturate", 32'(err_count), 255);
    cyc(9);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(3); cyc(4); cyc(5); cyc(5); cyc(4); cyc(4); cyc(4);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/gray_rx_decoder.md
GRAY_RX_DECODER -- requirements
Module: gray_rx_decoder

Interface
REQ-001 Parameter N, default 4, Gray code width in bits; legal range 2..16.
REQ-002 Parameter ERR_W, default 8, width of the saturating error counter.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 clk_en  input  1  sample enable; when low, the sample and decode state SHALL hold.
REQ-006 gray_in  input  N  reflected-binary Gray count from a gray counter; may be asynchronous to clk when GRAY_SYNC_EN is defined.
REQ-007 err_clr  input  1  single-cycle request to clear the fault state and err_count.
REQ-008 bin_out  output  N  registered binary decode of the latest accepted sample.
REQ-009 step_up  output  1  one-cycle pulse: accepted sample is previous value +1 mod 2^N.
REQ-010 step_dn  output  1  one-cycle pulse: accepted sample is previous value -1 mod 2^N.
REQ-011 err  output  1  one-cycle pulse: illegal transition detected.
REQ-012 locked  output  1  high while the FSM is in LOCK.
REQ-013 err_count  output  ERR_W  count of illegal transitions, saturating at 2^ERR_W-1.

Function
REQ-014 Decode SHALL be b[N-1]=g[N-1] and b[i]=b[i+1]^g[i] for i=N-2..0.
REQ-015 Sample register gray_q SHALL capture the (optionally synchronized) gray_in at every edge where clk_en=1.
REQ-016 At the edge after a gray_q capture, the block SHALL register bin_out=decode(gray_q) and compute delta=(decode(gray_q)-bin_prev) mod 2^N, then update bin_prev to decode(gray_q).
REQ-017 The FSM SHALL have states IDLE, LOCK and FAULT.
REQ-018 IDLE: the first decoded sample SHALL load bin_prev and bin_out, raise no pulse, and move to LOCK.
REQ-019 LOCK, delta=0: no pulse, stay in LOCK.
REQ-020 LOCK, delta=1: step_up, stay in LOCK; wrap 2^N-1 -> 0 SHALL count as step_up.
REQ-021 LOCK, delta=2^N-1: step_dn, stay in LOCK; wrap 0 -> 2^N-1 SHALL count as step_dn.
REQ-022 LOCK, any other delta: err pulse, err_count+1 (saturating), go to FAULT.
REQ-023 FAULT: bin_out and bin_prev SHALL keep updating; step_up/step_dn suppressed; further illegal deltas SHALL pulse err and increment err_count.
REQ-024 err_clr in any state SHALL zero err_count and move to IDLE at the next edge; it has priority over a simultaneous illegal transition, which then raises no err and no increment.
REQ-025 At most one of step_up, step_dn and err SHALL be high in any cycle; all three SHALL be low in cycles without a decode.
REQ-026 Latency gray_in -> bin_out/pulses SHALL be 2 clk_en-qualified edges without GRAY_SYNC_EN and 4 with it.
REQ-027 clk_en low SHALL suspend the pipeline without losing or duplicating a decode.

Reset
REQ-028 Reset SHALL set the FSM to IDLE and clear gray_q, bin_prev, bin_out, step_up, step_dn, err, locked, err_count and synchronizer flops to zero.
REQ-029 Reset asserted mid-operation SHALL take effect immediately, asynchronously; the first sample after release SHALL be treated as an IDLE acquisition.

Configuration
REQ-030 Macro GRAY_SYNC_EN defined: gray_in SHALL pass through a 2-flop synchronizer clocked every edge, not gated by clk_en, before gray_q.
REQ-031 GRAY_SYNC_EN undefined: gray_in SHALL feed gray_q directly; gray_in must be synchronous to clk.

Verification (N=4, no GRAY_SYNC_EN unless stated)
REQ-032 Reset, then gray_in 0000,0001,0011 with clk_en=1 -> locked=1, bin_out 0,1,2, step_up pulses on the 2nd and 3rd decodes, err_count=0.
REQ-033 Gray 1000 (bin 15) then 0000 -> step_up on the wrap, bin_out=0; reverse order -> step_dn.
REQ-034 Gray 0001 (1) then 0110 (4) -> err pulse, err_count=1, locked=0; a further 0111 (5) -> no step pulse, bin_out=5.
REQ-035 In FAULT, err_clr asserted with an illegal sample -> err_count=0, no err pulse, IDLE, then next sample -> LOCK with no pulse.
REQ-036 Force 300 illegal transitions with ERR_W=8 -> err_count holds 255.
REQ-037 GRAY_SYNC_EN defined, gray_in 0000 -> 0001 -> bin_out=1 and step_up exactly 4 edges later; rst_n pulsed low mid-stream -> all outputs 0 immediately.
